hazard_fwd_ctrl: RTL and testbench

- Central hazard/forwarding controller for the 5-stage MIPS pipeline.
- Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB destination/control fields and drives the pipeline in three ways:
  - EX-stage operand forwarding selects.
  - ID-stage writeback bypass selects for the register-file read-port muxes.
  - Load-use stalls, branch flush bubbles and whole-pipeline freeze on a slow data memory.
- Sits beside the datapath; owns no data, only selects and enables.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/fwd_select.sv | 25 ++
 rtl/hazard_fwd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: FSM states, forward selects, shadow record.
// Shadow-stage register addresses are RegAw bits wide; the controller's REG_AW defaults to it.
package hazard_pkg;

  localparam int unsigned RegAw = 5;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StMemWait   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic [RegAw-1:0] dest;
    logic [RegAw-1:0] rs;
    logic [RegAw-1:0] rt;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
  } stage_t;

  localparam stage_t StageBubble = '0;

endpackage

// File: rtl/fwd_select.sv
// EX-stage operand forward select for one source register.
// EX/MEM wins over MEM/WB; register $0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = RegAw
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] exmem_dest_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] memwb_dest_i,
  input  logic              memwb_regwrite_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (exmem_regwrite_i && (exmem_dest_i != '0) && (exmem_dest_i == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (memwb_regwrite_i && (memwb_dest_i != '0) && (memwb_dest_i == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: shadow stages, stalls, freezes, selects.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cycles counter and its port.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = RegAw
`ifdef HAZARD_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              wb_fwd_rs,
  output logic              wb_fwd_rt
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles
`endif
);

  stage_t idex_q, idex_d;
  stage_t exmem_q, exmem_d;
  stage_t memwb_q, memwb_d;
  state_e state_q, state_d;
  logic   lu, fz;

  always_comb begin
    lu = id_valid && idex_q.memread && (idex_q.dest != '0) &&
         ((id_uses_rs && (id_rs == idex_q.dest)) || (id_uses_rt && (id_rt == idex_q.dest)));
    fz = (exmem_q.memread || exmem_q.memwrite) && !mem_ready;
  end

  // Freeze beats flush beats load-use; flush is masked while reset holds outputs at rest.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (fz) begin
      pipe_freeze = 1'b1;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
    end else if (flush && !reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (!pipe_freeze) begin
      memwb_d = exmem_q;
      exmem_d = idex_q;
      if (idex_bubble || !id_valid) begin
        idex_d = StageBubble;
      end else begin
        idex_d.dest     = id_dest;
        idex_d.rs       = id_uses_rs ? id_rs : '0;
        idex_d.rt       = id_uses_rt ? id_rt : '0;
        idex_d.regwrite = id_regwrite;
        idex_d.memread  = id_memread;
        idex_d.memwrite = id_memwrite;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (fz) begin
          state_d = StMemWait;
        end else if (flush) begin
          state_d = StRun;
        end else if (lu) begin
          state_d = StLoadStall;
        end
      end
      StLoadStall: state_d = fz ? StMemWait : StRun;
      StMemWait:   state_d = fz ? StMemWait : StRun;
      default:     state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= StageBubble;
      exmem_q <= StageBubble;
      memwb_q <= StageBubble;
      state_q <= StRun;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      state_q <= state_d;
    end
  end

  fwd_select #(
    .REG_AW(REG_AW)
  ) u_fwd_a (
    .src_i           (idex_q.rs),
    .exmem_dest_i    (exmem_q.dest),
    .exmem_regwrite_i(exmem_q.regwrite),
    .memwb_dest_i    (memwb_q.dest),
    .memwb_regwrite_i(memwb_q.regwrite),
    .sel_o           (fwd_a)
  );

  fwd_select #(
    .REG_AW(REG_AW)
  ) u_fwd_b (
    .src_i           (idex_q.rt),
    .exmem_dest_i    (exmem_q.dest),
    .exmem_regwrite_i(exmem_q.regwrite),
    .memwb_dest_i    (memwb_q.dest),
    .memwb_regwrite_i(memwb_q.regwrite),
    .sel_o           (fwd_b)
  );

  always_comb begin
    wb_fwd_rs = memwb_q.regwrite && (memwb_q.dest != '0) && (memwb_q.dest == id_rs);
    wb_fwd_rt = memwb_q.regwrite && (memwb_q.dest != '0) && (memwb_q.dest == id_rt);
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl: stimulus pushes expected outputs, a monitor checks.
// Under HAZARD_STALL_CNT_EN the stall counter is checked as well.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_memwrite;
  logic       flush, mem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze;
  logic [1:0] fwd_a, fwd_b;
  logic       wb_fwd_rs, wb_fwd_rt;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_fwd_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_dest    (id_dest),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .id_memwrite(id_memwrite),
    .flush      (flush),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .wb_fwd_rs  (wb_fwd_rs),
    .wb_fwd_rt  (wb_fwd_rt)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, dest;
    logic       urs, urt, rw, mr, mw;
  } id_t;

  typedef struct {
    string       nm;
    logic [10:0] ov;
    logic        cc;
    int unsigned cnt;
  } exp_t;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b, wb_fwd_rs, wb_fwd_rt}
  localparam logic [10:0] E_NORM = 11'b11_000_00_00_00;
  localparam logic [10:0] E_LU   = 11'b00_010_00_00_00;
  localparam logic [10:0] E_FRZ  = 11'b00_001_00_00_00;
  localparam logic [10:0] E_FLSH = 11'b11_110_00_00_00;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [10:0] act;

  assign act = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze,
                fwd_a, fwd_b, wb_fwd_rs, wb_fwd_rt};

  function automatic logic [10:0] fw(input logic [10:0] base, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic wrs, input logic wrt);
    return base | {6'b0, fa, fb, wrs, wrt};
  endfunction

  function automatic id_t f_nop();
    id_t i;
    i = '{v: 1'b0, rs: 5'd0, rt: 5'd0, dest: 5'd0, urs: 1'b0, urt: 1'b0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0};
    return i;
  endfunction

  function automatic id_t f_alu(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] dst);
    id_t i;
    i = '{v: 1'b1, rs: rs, rt: rt, dest: dst, urs: 1'b1, urt: 1'b1,
          rw: 1'b1, mr: 1'b0, mw: 1'b0};
    return i;
  endfunction

  function automatic id_t f_lw(input logic [4:0] rs, input logic [4:0] dst);
    id_t i;
    i = '{v: 1'b1, rs: rs, rt: 5'd0, dest: dst, urs: 1'b1, urt: 1'b0,
          rw: 1'b1, mr: 1'b1, mw: 1'b0};
    return i;
  endfunction

  function automatic id_t f_sw(input logic [4:0] rs, input logic [4:0] rt);
    id_t i;
    i = '{v: 1'b1, rs: rs, rt: rt, dest: 5'd0, urs: 1'b1, urt: 1'b1,
          rw: 1'b0, mr: 1'b0, mw: 1'b1};
    return i;
  endfunction

  task automatic cyc(input string nm, input logic rst, input id_t i, input logic fl,
                     input logic rdy, input logic [10:0] ov, input int unsigned cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    id_valid    = i.v;
    id_rs       = i.rs;
    id_rt       = i.rt;
    id_dest     = i.dest;
    id_uses_rs  = i.urs;
    id_uses_rt  = i.urt;
    id_regwrite = i.rw;
    id_memread  = i.mr;
    id_memwrite = i.mw;
    flush       = fl;
    mem_ready   = rdy;
    e.nm  = nm;
    e.ov  = ov;
    e.cc  = 1'b1;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests++;
        if (act !== e.ov) begin
          fails++;
          $display("FAIL %s: outputs got %b required %b", e.nm, act, e.ov);
        end
`ifdef HAZARD_STALL_CNT_EN
        if (e.cc) begin
          tests++;
          if (stall_cycles !== e.cnt[15:0]) begin
            fails++;
            $display("FAIL %s_cnt: stall_cycles got %0d required %0d", e.nm, stall_cycles,
                     e.cnt);
          end
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    id_memwrite = 1'b0; flush = 1'b0; mem_ready = 1'b1;

    cyc("reset",          1'b1, f_nop(),               1'b0, 1'b1, E_NORM, 0);
    // Load-use: lw $2 then add $3,$2,$4
    cyc("lw2_issue",      1'b0, f_lw(5'd1, 5'd2),      1'b0, 1'b1, E_NORM, 0);
    cyc("lu_stall",       1'b0, f_alu(5'd2, 5'd4, 5'd3), 1'b0, 1'b1, E_LU, 0);
    cyc("lu_release",     1'b0, f_alu(5'd2, 5'd4, 5'd3), 1'b0, 1'b1, E_NORM, 1);
    cyc("fwd_memwb",      1'b0, f_nop(), 1'b0, 1'b1, fw(E_NORM, 2'b01, 2'b00, 1'b0, 1'b0), 1);
    // Two producers of $5; EX/MEM copy must win
    cyc("a5_first",       1'b0, f_alu(5'd1, 5'd1, 5'd5), 1'b0, 1'b1, E_NORM, 1);
    cyc("a5_second",      1'b0, f_alu(5'd1, 5'd1, 5'd5), 1'b0, 1'b1, E_NORM, 1);
    cyc("rd5_issue",      1'b0, f_alu(5'd5, 5'd6, 5'd7), 1'b0, 1'b1, E_NORM, 1);
    cyc("fwd_exmem_prio", 1'b0, f_nop(), 1'b0, 1'b1, fw(E_NORM, 2'b10, 2'b00, 1'b0, 1'b0), 1);
    // Load into $0: no stall, no forward, no writeback bypass
    cyc("lw0_issue",      1'b0, f_lw(5'd1, 5'd0),      1'b0, 1'b1, E_NORM, 1);
    cyc("lw0_no_stall",   1'b0, f_alu(5'd0, 5'd0, 5'd8), 1'b0, 1'b1, E_NORM, 1);
    cyc("fwd_zero_exmem", 1'b0, f_nop(),               1'b0, 1'b1, E_NORM, 1);
    cyc("wb_zero",        1'b0, f_nop(),               1'b0, 1'b1, E_NORM, 1);
    cyc("reset2",         1'b1, f_nop(),               1'b0, 1'b1, E_NORM, 0);
    // add $7 then sw reaches EX/MEM and memory is slow for three cycles
    cyc("a7_issue",       1'b0, f_alu(5'd1, 5'd1, 5'd7), 1'b0, 1'b1, E_NORM, 0);
    cyc("sw_issue",       1'b0, f_sw(5'd1, 5'd2),      1'b0, 1'b1, E_NORM, 0);
    cyc("sw_to_exmem",    1'b0, f_nop(),               1'b0, 1'b1, E_NORM, 0);
    cyc("freeze1",        1'b0, f_alu(5'd7, 5'd7, 5'd9), 1'b0, 1'b0,
        fw(E_FRZ, 2'b00, 2'b00, 1'b1, 1'b1), 0);
    cyc("freeze2",        1'b0, f_alu(5'd7, 5'd7, 5'd9), 1'b0, 1'b0,
        fw(E_FRZ, 2'b00, 2'b00, 1'b1, 1'b1), 1);
    cyc("freeze3_flush",  1'b0, f_alu(5'd7, 5'd7, 5'd9), 1'b1, 1'b0,
        fw(E_FRZ, 2'b00, 2'b00, 1'b1, 1'b1), 2);
    cyc("freeze_done",    1'b0, f_alu(5'd7, 5'd7, 5'd9), 1'b0, 1'b1,
        fw(E_NORM, 2'b00, 2'b00, 1'b1, 1'b1), 3);
    cyc("post_freeze",    1'b0, f_nop(),               1'b0, 1'b1, E_NORM, 3);
    // Flush in the same cycle as a load-use hazard
    cyc("lw2b_issue",     1'b0, f_lw(5'd1, 5'd2),      1'b0, 1'b1, E_NORM, 3);
    cyc("flush_over_lu",  1'b0, f_alu(5'd2, 5'd4, 5'd3), 1'b1, 1'b1, E_FLSH, 3);
    cyc("after_flush",    1'b0, f_nop(),               1'b0, 1'b1, E_NORM, 3);
    // Reset while waiting on memory
    cyc("lw6_issue",      1'b0, f_lw(5'd1, 5'd6),      1'b0, 1'b1, E_NORM, 3);
    cyc("lw6_to_ex",      1'b0, f_nop(),               1'b0, 1'b1, E_NORM, 3);
    cyc("memwait1",       1'b0, f_nop(),               1'b0, 1'b0, E_FRZ, 3);
    cyc("memwait2",       1'b0, f_nop(),               1'b0, 1'b0, E_FRZ, 4);
    cyc("reset_in_wait",  1'b1, f_nop(),               1'b1, 1'b0, E_NORM, 0);
    cyc("after_reset",    1'b0, f_nop(),               1'b0, 1'b0, E_NORM, 0);

    for (int k = 0; k < 10; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
